// File: rtl/cache_request_issuer.sv
// cache_request_issuer: queues core load/store requests and launches them one at
// a time onto the local router port. Loads block until the tagged response arrives
// or a timeout expires; stores are posted. Request order is strictly preserved.
module cache_request_issuer #(
   parameter int DATA_WIDTH               = 32,
   parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
   parameter int NETWORK_ADDRESS_WIDTH    = 4,
   parameter int LOCAL_ADDRESS            = 0,
   parameter int QUEUE_DEPTH              = 4,
   parameter int TIMEOUT_CYCLES           = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                coreReqValid,
   output logic                                coreReqReady,
   input  logic                                coreReqWrite,
   input  logic [NETWORK_ADDRESS_WIDTH-1:0]    coreReqDest,
   input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] coreReqAddr,
   input  logic [DATA_WIDTH-1:0]               coreReqData,
   output logic                                coreRespValid,
   input  logic                                coreRespReady,
   output logic [DATA_WIDTH-1:0]               coreRespData,
   output logic                                coreRespError,
   input  logic                                netReady,
   output logic [NETWORK_ADDRESS_WIDTH-1:0]    destAddressOut,
   output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressOut,
   output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut,
   output logic                                memRead,
   output logic                                memWrite,
   output logic [DATA_WIDTH-1:0]               dataOut,
   input  logic                                readReady,
   input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
   input  logic [DATA_WIDTH-1:0]               cacheDataIn,
   output logic                                busy
);

   localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH);
   localparam int COUNT_WIDTH = PTR_WIDTH + 1;
   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
   localparam int ENTRY_WIDTH = 1 + NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH + DATA_WIDTH;

   localparam logic [COUNT_WIDTH-1:0]           FULL_COUNT = COUNT_WIDTH'(QUEUE_DEPTH);
   localparam logic [TIMER_WIDTH-1:0]           TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [NETWORK_ADDRESS_WIDTH-1:0] LOCAL_TAG  = NETWORK_ADDRESS_WIDTH'(LOCAL_ADDRESS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_READ = 2'd1,
      RESPOND   = 2'd2
   } issuerState_t;

   issuerState_t state, stateNext;

   // Request FIFO storage and bookkeeping
   logic [ENTRY_WIDTH-1:0]  fifoMem [QUEUE_DEPTH];
   logic [PTR_WIDTH-1:0]    wrPtr, rdPtr;
   logic [COUNT_WIDTH-1:0]  count;
   logic                    push, pop;

   // Head-of-queue fields
   logic                                headWrite;
   logic [NETWORK_ADDRESS_WIDTH-1:0]    headDest;
   logic [CACHE_BANK_ADDRESS_WIDTH-1:0] headAddr;
   logic [DATA_WIDTH-1:0]               headData;

   // Next-state values for the registered outputs
   logic [TIMER_WIDTH-1:0]              timer, timerNext;
   logic [DATA_WIDTH-1:0]               respDataNext;
   logic                                respErrorNext;
   logic                                memReadNext, memWriteNext;
   logic [NETWORK_ADDRESS_WIDTH-1:0]    destNext;
   logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddrNext;
   logic [DATA_WIDTH-1:0]               dataOutNext;

   assign coreReqReady        = (count != FULL_COUNT);
   assign push                = coreReqValid && coreReqReady;
   // Launching only happens from IDLE, so a blocking read holds back every later request.
   assign pop                 = (state == IDLE) && (count != '0) && netReady;
   assign {headWrite, headDest, headAddr, headData} = fifoMem[rdPtr];
   assign coreRespValid       = (state == RESPOND);
   assign requesterAddressOut = LOCAL_TAG;
   assign busy                = (count != '0) || (state != IDLE);

   // FIFO storage write; contents need no reset because count guards every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= {coreReqWrite, coreReqDest, coreReqAddr, coreReqData};
      end
   end

   // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_WIDTH'(1);
         if (pop)  rdPtr <= rdPtr + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   count <= count + COUNT_WIDTH'(1);
            2'b01:   count <= count - COUNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state logic: launch, wait for tagged response or timeout, hand result to core
   always_comb begin
      stateNext     = state;
      timerNext     = timer;
      respDataNext  = coreRespData;
      respErrorNext = coreRespError;
      memReadNext   = 1'b0;
      memWriteNext  = 1'b0;
      destNext      = destAddressOut;
      cacheAddrNext = cacheAddressOut;
      dataOutNext   = dataOut;
      case (state)
         IDLE: begin
            if (pop) begin
               destNext      = headDest;
               cacheAddrNext = headAddr;
               dataOutNext   = headData;
               if (headWrite) begin
                  memWriteNext = 1'b1;
               end else begin
                  memReadNext = 1'b1;
                  timerNext   = '0;
                  stateNext   = WAIT_READ;
               end
            end
         end
         WAIT_READ: begin
            // A matching response beats the timeout when both land in the same cycle.
            if (readReady && (requesterAddressIn == LOCAL_TAG)) begin
               respDataNext  = cacheDataIn;
               respErrorNext = 1'b0;
               stateNext     = RESPOND;
            end else if (timer == TIMER_LAST) begin
               respDataNext  = '0;
               respErrorNext = 1'b1;
               stateNext     = RESPOND;
            end else if (timer != '1) begin
               timerNext = timer + TIMER_WIDTH'(1);
            end
         end
         RESPOND: begin
            if (coreRespReady) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Registered network fields, strobes, timer and core response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer           <= '0;
         coreRespData    <= '0;
         coreRespError   <= 1'b0;
         memRead         <= 1'b0;
         memWrite        <= 1'b0;
         destAddressOut  <= '0;
         cacheAddressOut <= '0;
         dataOut         <= '0;
      end else begin
         timer           <= timerNext;
         coreRespData    <= respDataNext;
         coreRespError   <= respErrorNext;
         memRead         <= memReadNext;
         memWrite        <= memWriteNext;
         destAddressOut  <= destNext;
         cacheAddressOut <= cacheAddrNext;
         dataOut         <= dataOutNext;
      end
   end

endmodule

// File: tb/tb_cache_request_issuer.sv
// Bench for cache_request_issuer: stimulus pushes expected launches into a queue,
// an arbiter model plans each load's response and queues the expected core result,
// and a monitor compares every strobe and every core response against the queues.
module tb_cache_request_issuer;

   localparam int DW    = 32;
   localparam int CBAW  = 8;
   localparam int NAW   = 4;
   localparam int LOCAL = 3;
   localparam int QD    = 4;
   localparam int TMO   = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            coreReqValid = 1'b0;
   logic            coreReqReady;
   logic            coreReqWrite = 1'b0;
   logic [NAW-1:0]  coreReqDest = '0;
   logic [CBAW-1:0] coreReqAddr = '0;
   logic [DW-1:0]   coreReqData = '0;
   logic            coreRespValid;
   logic            coreRespReady = 1'b0;
   logic [DW-1:0]   coreRespData;
   logic            coreRespError;
   logic            netReady = 1'b0;
   logic [NAW-1:0]  destAddressOut;
   logic [CBAW-1:0] cacheAddressOut;
   logic [NAW-1:0]  requesterAddressOut;
   logic            memRead;
   logic            memWrite;
   logic [DW-1:0]   dataOut;
   logic            readReady = 1'b0;
   logic [NAW-1:0]  requesterAddressIn = '0;
   logic [DW-1:0]   cacheDataIn = '0;
   logic            busy;

   cache_request_issuer #(
      .DATA_WIDTH(DW), .CACHE_BANK_ADDRESS_WIDTH(CBAW), .NETWORK_ADDRESS_WIDTH(NAW),
      .LOCAL_ADDRESS(LOCAL), .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .coreReqValid(coreReqValid), .coreReqReady(coreReqReady), .coreReqWrite(coreReqWrite),
      .coreReqDest(coreReqDest), .coreReqAddr(coreReqAddr), .coreReqData(coreReqData),
      .coreRespValid(coreRespValid), .coreRespReady(coreRespReady),
      .coreRespData(coreRespData), .coreRespError(coreRespError),
      .netReady(netReady), .destAddressOut(destAddressOut), .cacheAddressOut(cacheAddressOut),
      .requesterAddressOut(requesterAddressOut), .memRead(memRead), .memWrite(memWrite),
      .dataOut(dataOut), .readReady(readReady), .requesterAddressIn(requesterAddressIn),
      .cacheDataIn(cacheDataIn), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit              write;
      logic [NAW-1:0]  dest;
      logic [CBAW-1:0] addr;
      logic [DW-1:0]   data;
   } launch_t;

   typedef struct {
      logic [DW-1:0] data;
      bit            err;
      int            validCyc;
   } resp_t;

   launch_t launchQ[$];
   resp_t   respQ[$];

   int compared = 0;
   int mismatched = 0;

   // Stimulus-owned controls
   bit            randomNet = 1'b0;
   bit            netDrive = 1'b1;
   int            forceK = -1;
   logic [DW-1:0] forceData = '0;
   bit            silentResp = 1'b0;
   int            injectLateAt = -1;
   int            fifoCount = 0;

   // Monitor-owned observations
   bit      readOutstanding = 1'b0;
   bit      respHeld = 1'b0;
   int      lastWriteCyc = -1;
   int      lastReadCyc = -1;
   int      strobeCount = 0;
   launch_t curLaunch;
   resp_t   curResp;

   // Responder-owned state
   int            respondAt = -1;
   logic [DW-1:0] respondData = '0;
   int            respK;
   logic [DW-1:0] respD;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic launch_t randReq();
      launch_t r;
      r.write = 1'($urandom_range(0, 1));
      r.dest  = NAW'($urandom);
      r.addr  = CBAW'($urandom);
      r.data  = DW'($urandom);
      return r;
   endfunction

   // Arbiter model: plans the response to each load and queues the result the core must see
   always @(negedge clk) begin
      if (reset) begin
         respondAt = -1;
         respQ.delete();
         readReady = 1'b0;
      end else begin
         if (memRead) begin
            if (forceK >= 0) begin
               respK = forceK;
               respD = forceData;
            end else begin
               case ($urandom_range(0, 7))
                  0:       respK = TMO - 1;
                  1:       respK = TMO + int'($urandom_range(0, 1));
                  2:       respK = -1;
                  default: respK = int'($urandom_range(0, 5));
               endcase
               respD = DW'($urandom);
            end
            if (silentResp) respK = -1;
            if (respK >= 0 && respK <= TMO - 1)
               respQ.push_back('{data: respD, err: 1'b0, validCyc: cyc + respK + 1});
            else
               respQ.push_back('{data: '0, err: 1'b1, validCyc: cyc + TMO});
            respondAt   = (respK >= 0) ? cyc + respK : -1;
            respondData = respD;
         end
         if (cyc == respondAt || cyc == injectLateAt) begin
            readReady          = 1'b1;
            requesterAddressIn = NAW'(LOCAL);
            cacheDataIn        = respondData;
            if (cyc == respondAt) respondAt = -1;
         end else if ($urandom_range(0, 5) == 0) begin
            readReady          = 1'b1;
            requesterAddressIn = NAW'(LOCAL + 1 + int'($urandom_range(0, 14)));
            cacheDataIn        = DW'($urandom);
         end else begin
            readReady          = 1'b0;
            requesterAddressIn = NAW'($urandom);
            cacheDataIn        = DW'($urandom);
         end
      end
   end

   // Monitor: checks every launch strobe and every core response against the queues
   always @(negedge clk) begin
      if (reset) begin
         respHeld        = 1'b0;
         readOutstanding = 1'b0;
         coreRespReady   = 1'b0;
      end else begin
         if (memRead || memWrite) begin
            strobeCount++;
            check("strobe_kind_exclusive", 64'(memRead && memWrite), 64'd0);
            check("no_launch_while_load_pending", 64'(readOutstanding), 64'd0);
            check("requester_tag", 64'(requesterAddressOut), 64'(LOCAL));
            if (launchQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_launch: got strobe write=%0b, expected none (cycle %0d)", memWrite, cyc);
            end else begin
               curLaunch = launchQ.pop_front();
               check("launch_is_write", 64'(memWrite), 64'(curLaunch.write));
               check("launch_dest", 64'(destAddressOut), 64'(curLaunch.dest));
               check("launch_addr", 64'(cacheAddressOut), 64'(curLaunch.addr));
               check("launch_data", 64'(dataOut), 64'(curLaunch.data));
               $display("launch %s dest=%0h addr=%02h data=%08h cycle=%0d",
                        memWrite ? "write" : "read ", destAddressOut, cacheAddressOut, dataOut, cyc);
            end
            if (memWrite) lastWriteCyc = cyc;
            if (memRead) begin
               lastReadCyc     = cyc;
               readOutstanding = 1'b1;
            end
         end
         if (coreRespValid) begin
            if (!respHeld) begin
               if (respQ.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_response: got data=%08h err=%0b, expected none (cycle %0d)",
                           coreRespData, coreRespError, cyc);
                  curResp = '{data: coreRespData, err: coreRespError, validCyc: cyc};
               end else begin
                  curResp = respQ.pop_front();
                  check("resp_valid_cycle", 64'(cyc), 64'(curResp.validCyc));
               end
               respHeld = 1'b1;
            end
            check("resp_data", 64'(coreRespData), 64'(curResp.data));
            check("resp_error", 64'(coreRespError), 64'(curResp.err));
            coreRespReady = ($urandom_range(0, 2) != 0);
            if (coreRespReady) begin
               respHeld        = 1'b0;
               readOutstanding = 1'b0;
               $display("response data=%08h err=%0b cycle=%0d", coreRespData, coreRespError, cyc);
            end
         end else begin
            coreRespReady = 1'b1 & 1'($urandom_range(0, 1));
         end
      end
   end

   // One bench cycle: track occupancy, check ready, then drive the next request
   task automatic step(input bit v, input launch_t r);
      @(negedge clk);
      if (memRead || memWrite) fifoCount--;
      check("core_req_ready", 64'(coreReqReady), 64'(fifoCount < QD));
      netReady     = randomNet ? ($urandom_range(0, 9) < 7) : netDrive;
      coreReqValid = v;
      coreReqWrite = r.write;
      coreReqDest  = r.dest;
      coreReqAddr  = r.addr;
      coreReqData  = r.data;
      if (v && fifoCount < QD) begin
         launchQ.push_back(r);
         fifoCount++;
      end
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((launchQ.size() != 0 || respQ.size() != 0 || busy || coreRespValid) && n < budget) begin
         step(1'b0, randReq());
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   int pushCyc;
   int strobeSnap;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("reset_core_req_ready", 64'(coreReqReady), 64'd1);
      check("reset_mem_read", 64'(memRead), 64'd0);
      check("reset_mem_write", 64'(memWrite), 64'd0);
      check("reset_dest", 64'(destAddressOut), 64'd0);
      check("reset_cache_addr", 64'(cacheAddressOut), 64'd0);
      check("reset_data_out", 64'(dataOut), 64'd0);
      check("reset_resp_valid", 64'(coreRespValid), 64'd0);
      check("reset_resp_data", 64'(coreRespData), 64'd0);
      check("reset_resp_error", 64'(coreRespError), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      #1 reset = 1'b0;

      // Write then read, arbiter answers two cycles after the load strobe
      netDrive  = 1'b1;
      forceK    = 2;
      forceData = 32'hDEADBEEF;
      step(1'b1, '{1'b1, 4'd2, 8'h10, 32'h12345678});
      pushCyc = cyc;
      step(1'b1, '{1'b0, 4'd1, 8'h20, 32'h0});
      drain(200, "drain_write_read");
      check("write_launch_latency", 64'(lastWriteCyc), 64'(pushCyc + 2));
      check("read_follows_write", 64'(lastReadCyc), 64'(lastWriteCyc + 1));
      forceK = -1;

      // Five pushes into a four-entry queue with the network stalled, then drain in order
      netDrive = 1'b0;
      step(1'b0, randReq());
      for (int i = 0; i < 5; i++) begin
         step(1'b1, '{1'b1, NAW'(i), CBAW'(8'h40 + i), DW'(32'hA000 + i)});
      end
      netDrive = 1'b1;
      drain(200, "drain_full_queue");

      // Load with only foreign responses: timeout, then a late matching pulse is ignored
      silentResp = 1'b1;
      step(1'b1, '{1'b0, 4'd7, 8'h33, 32'h0});
      drain(200, "drain_timeout");
      silentResp   = 1'b0;
      injectLateAt = cyc + 2;
      repeat (6) step(1'b0, randReq());
      injectLateAt = -1;

      // Matching response in the last timeout cycle wins
      forceK    = TMO - 1;
      forceData = 32'hCAFEF00D;
      step(1'b1, '{1'b0, 4'd5, 8'h44, 32'h0});
      drain(200, "drain_last_cycle_match");

      // Load followed by a queued store: the store waits for the core handshake
      forceK    = 6;
      forceData = 32'h0BADF00D;
      step(1'b1, '{1'b0, 4'd6, 8'h55, 32'h0});
      step(1'b1, '{1'b1, 4'd6, 8'h56, 32'h77777777});
      drain(200, "drain_read_then_write");
      forceK = -1;

      // Reset while a load is pending and two stores are queued
      silentResp = 1'b1;
      step(1'b1, '{1'b0, 4'd9, 8'h66, 32'h0});
      step(1'b1, '{1'b1, 4'd9, 8'h67, 32'h1});
      step(1'b1, '{1'b1, 4'd9, 8'h68, 32'h2});
      step(1'b0, randReq());
      check("busy_before_reset", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      coreReqValid = 1'b0;
      #1;
      check("async_reset_mem_read", 64'(memRead), 64'd0);
      check("async_reset_mem_write", 64'(memWrite), 64'd0);
      check("async_reset_busy", 64'(busy), 64'd0);
      check("async_reset_req_ready", 64'(coreReqReady), 64'd1);
      check("async_reset_resp_valid", 64'(coreRespValid), 64'd0);
      check("async_reset_dest", 64'(destAddressOut), 64'd0);
      check("async_reset_cache_addr", 64'(cacheAddressOut), 64'd0);
      launchQ.delete();
      fifoCount = 0;
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      silentResp   = 1'b0;
      strobeSnap   = strobeCount;
      injectLateAt = cyc + 3;
      repeat (10) step(1'b0, randReq());
      injectLateAt = -1;
      check("no_strobe_after_reset", 64'(strobeCount), 64'(strobeSnap));
      check("idle_after_reset", 64'(busy), 64'd0);

      // Randomized traffic with random network back-pressure and response timing
      randomNet = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)), randReq());
      end
      randomNet = 1'b0;
      netDrive  = 1'b1;
      drain(3000, "drain_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cache_request_issuer.md
# cache_request_issuer

Requester-side endpoint for the cache access network. Accepts load/store requests from the local core, queues them, and launches them one at a time into the local router port as memRead/memWrite requests tagged with this node's network address. It waits for the matching readReady response from the remote cache access arbiter and returns read data, or a timeout error, to the core. Writes are posted; reads are blocking, and strict request order is preserved.

## Interface
- DATA_WIDTH, 32, data word width
- CACHE_BANK_ADDRESS_WIDTH, 8, word address within a cache bank
- NETWORK_ADDRESS_WIDTH, 4, router node ID width
- LOCAL_ADDRESS, 0, this node's network address; driven as requester tag and used for response matching
- QUEUE_DEPTH, 4, core request FIFO entries (power of 2, ≥2)
- TIMEOUT_CYCLES, 64, WAIT_READ cycles before error (≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- coreReqValid  in  1  core request present
- coreReqReady  out  1  FIFO not full (combinational from count)
- coreReqWrite  in  1  1=store, 0=load
- coreReqDest  in  NETWORK_ADDRESS_WIDTH  target node holding the cache bank
- coreReqAddr  in  CACHE_BANK_ADDRESS_WIDTH  bank word address
- coreReqData  in  DATA_WIDTH  store data (ignored for loads)
- coreRespValid  out  1  load result available
- coreRespReady  in  1  core accepts result
- coreRespData  out  DATA_WIDTH  load data (0 on error)
- coreRespError  out  1  load timed out
- netReady  in  1  router port can take a request next cycle
- destAddressOut  out  NETWORK_ADDRESS_WIDTH  request destination
- cacheAddressOut  out  CACHE_BANK_ADDRESS_WIDTH  bank address
- requesterAddressOut  out  NETWORK_ADDRESS_WIDTH  always LOCAL_ADDRESS
- memRead  out  1  one-cycle read request strobe
- memWrite  out  1  one-cycle write request strobe
- dataOut  out  DATA_WIDTH  write data
- readReady  in  1  response strobe from network
- requesterAddressIn  in  NETWORK_ADDRESS_WIDTH  response tag
- cacheDataIn  in  DATA_WIDTH  response data
- busy  out  1  FIFO non-empty or state≠IDLE

## Operation
- FIFO: push on coreReqValid&&coreReqReady; stores {write,dest,addr,data}. Push and pop in the same cycle are both performed. Pointers are log2(QUEUE_DEPTH) bits and wrap; count is log2(QUEUE_DEPTH)+1 bits.
- FSM states: IDLE, WAIT_READ, RESPOND.
- IDLE, FIFO non-empty, netReady=1: pop the head and register destAddressOut/cacheAddressOut/dataOut.
  - Write head: memWrite<=1; stay IDLE.
  - Read head: memRead<=1; timer<=0; go to WAIT_READ.
- IDLE with FIFO empty or netReady=0: memRead/memWrite<=0; field outputs hold their last values.
- WAIT_READ: no pops (later writes wait).
  - readReady=1 and requesterAddressIn==LOCAL_ADDRESS: capture cacheDataIn into coreRespData, error<=0, go to RESPOND.
  - Otherwise, if timer==TIMEOUT_CYCLES-1: data<=0, error<=1, go to RESPOND.
  - Otherwise timer++.
  - A match and the timeout in the same cycle: the match wins.
- Non-matching readReady is ignored in every state. A late response arriving after a timeout is discarded.
- RESPOND: coreRespValid=1, data and error held stable. On coreRespReady, go to IDLE. The next pop may occur in that first IDLE cycle.
- The timer is log2(TIMEOUT_CYCLES) bits wide and saturates.

## Timing
- Reset values: state IDLE; FIFO empty; coreReqReady=1; memRead=memWrite=0; dest/cache/dataOut=0; coreRespValid=0, coreRespData=0, coreRespError=0; busy=0; timer=0.
- Reset mid-operation aborts the outstanding read and flushes queued requests. A response that arrives afterwards is ignored.
- Push-to-launch latency: a request pushed at edge N can pop at edge N+1 (it is in the FIFO after edge N). Its strobe is visible in cycle N+1→N+2.
- Strobes last exactly one cycle per request. Back-to-back writes give a continuous memWrite high with changing fields.
- A response is accepted in any WAIT_READ cycle, including the cycle in which memRead is high. coreRespValid rises the cycle after the matching readReady.
- Load round trip (fixed-latency arbiter of L cycles): coreRespValid follows memRead by L+1 cycles.

## Test plan
- Write then read, netReady=1, arbiter responds 2 cycles later with tag LOCAL_ADDRESS and data 0xDEADBEEF. Expected:
  - memWrite is high one cycle.
  - memRead is high the next cycle.
  - coreRespData=0xDEADBEEF with error=0, held until coreRespReady.
- Push 5 requests with QUEUE_DEPTH=4 and netReady=0. Expected:
  - coreReqReady drops after the 4th push; the 5th is not accepted.
  - Raising netReady drains the requests in order, and ready reasserts after the first pop.
- Read outstanding with readReady pulses tagged LOCAL_ADDRESS+1, then no response. Expected:
  - The foreign responses are ignored.
  - coreRespError=1 and data=0 after TIMEOUT_CYCLES WAIT_READ cycles.
  - A late matching response is discarded.
- Read followed by a queued write. Expected: memWrite does not assert until RESPOND is exited via coreRespReady.
- Matching response in the final timeout cycle. Expected: error=0 and the captured data is returned.
- Assert reset during WAIT_READ with 2 queued entries. Expected:
  - All outputs reset immediately (asynchronously).
  - busy=0.
  - No strobes after release until new pushes.
